// File: rtl/putbits.sv
`default_nettype none
// ============================================================================
//  Module   : putbits
//  Purpose  : MSB-first bitstream writer. Packs variable-length fields
//             (0..32 bits) into a byte stream, supports byte alignment with
//             zero padding, and keeps a running count of emitted bits.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_valid/in_ready   - command handshake
//             in_val, in_n        - field value (right-justified) and length
//             in_align            - pad with zeros to the next byte boundary
//             out_valid/out_ready - byte handshake
//             out_byte            - next stream byte
//             bitcount            - total bits accepted (mod 2^32)
//             idle                - no pending bits
//  Revision : 1.0 - initial release
// ============================================================================
module putbits #(
    parameter int ACC_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_val,
    input  logic [5:0]  in_n,
    input  logic        in_align,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic [31:0] bitcount,
    output logic        idle
);

    localparam logic [6:0] c_MAX_N = 7'd32;
    localparam logic [6:0] c_ACC_W = 7'(ACC_W);

    // Pending bits are left-justified: the oldest bit sits at the MSB and
    // everything below the valid count is kept at zero, so insertion is a
    // plain OR and a pop is a plain shift.
    logic [ACC_W-1:0] r_acc;
    logic [6:0]       r_cnt;
    logic [31:0]      r_bitcount;

    logic             w_pop;
    logic             w_take;
    logic [ACC_W-1:0] w_acc_p;
    logic [6:0]       w_cnt_p;
    logic [6:0]       w_n;
    logic [ACC_W-1:0] w_mask;
    logic [ACC_W-1:0] w_field;
    logic [6:0]       w_shamt;
    logic [ACC_W-1:0] w_ins;
    logic [6:0]       w_pad;
    logic [6:0]       w_add;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [6:0]       w_cnt_nxt;
    logic [31:0]      w_bitcount_nxt;

    // All outputs come from registered state only.
    assign in_ready  = (r_cnt <= 7'd32);
    assign out_valid = (r_cnt >= 7'd8);
    assign out_byte  = r_acc[ACC_W-1 -: 8];
    assign idle      = (r_cnt == 7'd0);
    assign bitcount  = r_bitcount;

    assign w_pop  = out_valid && out_ready;
    assign w_take = in_valid && in_ready;

    always_comb begin
        w_acc_p        = r_acc;
        w_cnt_p        = r_cnt;
        w_n            = {1'b0, in_n};
        w_mask         = '0;
        w_field        = '0;
        w_shamt        = '0;
        w_ins          = '0;
        w_pad          = '0;
        w_add          = '0;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_bitcount_nxt = r_bitcount;

        // Pop is applied first so an accept in the same cycle lands right
        // behind the remaining bits.
        if (w_pop) begin
            w_acc_p = {r_acc[ACC_W-9:0], 8'h00};
            w_cnt_p = r_cnt - 7'd8;
        end

        if (w_n > c_MAX_N) begin
            w_n = c_MAX_N;
        end

        // Mask of n ones (n = 0 gives an empty mask).
        w_mask  = {{(ACC_W-32){1'b0}}, 32'hFFFF_FFFF} >> (c_MAX_N - w_n);
        w_field = {{(ACC_W-32){1'b0}}, in_val} & w_mask;

        // Accept only happens with c' <= 32 and n <= 32, so the shift is
        // bounded by 0..64; a shift of 64 only occurs with an empty field.
        w_shamt = c_ACC_W - w_cnt_p - w_n;
        w_ins   = w_field << w_shamt;

        w_pad   = {4'd0, 3'd0 - w_cnt_p[2:0]};
        w_add   = in_align ? w_pad : w_n;

        w_acc_nxt = w_acc_p;
        w_cnt_nxt = w_cnt_p;
        if (w_take) begin
            // Padding bits are zeros, already present below the count.
            if (!in_align) begin
                w_acc_nxt = w_acc_p | w_ins;
            end
            w_cnt_nxt      = w_cnt_p + w_add;
            w_bitcount_nxt = r_bitcount + {25'd0, w_add};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_bitcount <= '0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bitcount <= w_bitcount_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_putbits.sv
`default_nettype none
// ============================================================================
//  Module   : tb_putbits
//  Purpose  : Directed self-checking bench for putbits.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_putbits;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_val;
    logic [5:0]  in_n;
    logic        in_align;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [31:0] bitcount;
    logic        idle;

    int n_cmp;
    int n_fail;

    logic [7:0] r_bytes[$];

    putbits #(.ACC_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .in_n      (in_n),
        .in_align  (in_align),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .bitcount  (bitcount),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change only 1 time unit after a rising edge, so the values seen
    // on the falling edge are the ones the next rising edge will use.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            r_bytes.push_back(out_byte);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_val    = '0;
        in_n      = '0;
        in_align  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        r_bytes.delete();
    endtask

    // Present one command and hold it until accepted (bounded).
    task automatic send(input logic [31:0] val, input logic [5:0] n, input logic align);
        int guard;
        in_valid = 1'b1;
        in_val   = val;
        in_n     = n;
        in_align = align;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        in_align = 1'b0;
    endtask

    task automatic wait_bytes(input int k);
        int guard;
        guard = 0;
        while (r_bytes.size() < k && guard < 200) begin
            step();
            guard++;
        end
        n_cmp++;
        if (r_bytes.size() !== k) begin
            n_fail++;
            $display("FAIL byte_count: got %0d bytes required %0d", r_bytes.size(), k);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: %0b req 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: %0b req 0", out_valid); end
        n_cmp++; if (idle !== 1'b1)       begin n_fail++; $display("FAIL reset_idle: %0b req 1", idle); end
        n_cmp++; if (bitcount !== 32'd0)  begin n_fail++; $display("FAIL reset_bitcount: %0d req 0", bitcount); end
        n_cmp++; if (out_byte !== 8'h00)  begin n_fail++; $display("FAIL reset_out_byte: %02h req 00", out_byte); end
    endtask

    task automatic test_start_code();
        logic [7:0] exp_b[4];
        exp_b[0] = 8'h00; exp_b[1] = 8'h00; exp_b[2] = 8'h01; exp_b[3] = 8'hB3;
        do_reset();
        out_ready = 1'b1;
        send(32'h0000_01B3, 6'd32, 1'b0);
        // One cycle after the accept edge the first byte is presented.
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_byte !== exp_b[i]) begin
                n_fail++;
                $display("FAIL start_byte%0d: valid=%0b byte=%02h req valid=1 byte=%02h", i, out_valid, out_byte, exp_b[i]);
            end
            step();
        end
        n_cmp++; if (bitcount !== 32'd32) begin n_fail++; $display("FAIL start_bitcount: %0d req 32", bitcount); end
        n_cmp++; if (idle !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL start_idle: idle=%0b valid=%0b req 1/0", idle, out_valid); end
    endtask

    task automatic test_align();
        do_reset();
        out_ready = 1'b1;
        send(32'h5, 6'd3, 1'b0);
        n_cmp++; if (out_valid !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL align_partial: valid=%0b idle=%0b req 0/0", out_valid, idle); end
        n_cmp++; if (bitcount !== 32'd3) begin n_fail++; $display("FAIL align_bc3: %0d req 3", bitcount); end
        send(32'hFFFF_FFFF, 6'd17, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || out_byte !== 8'hA0) begin n_fail++; $display("FAIL align_byte: valid=%0b byte=%02h req 1/A0", out_valid, out_byte); end
        n_cmp++; if (bitcount !== 32'd8) begin n_fail++; $display("FAIL align_bc8: %0d req 8", bitcount); end
        step();
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL align_drained: idle=%0b req 1", idle); end
        send(32'h0, 6'd0, 1'b1);
        step();
        n_cmp++; if (bitcount !== 32'd8 || idle !== 1'b1) begin n_fail++; $display("FAIL align_noop: bc=%0d idle=%0b req 8/1", bitcount, idle); end
        n_cmp++; if (r_bytes.size() !== 1) begin n_fail++; $display("FAIL align_nbytes: %0d req 1", r_bytes.size()); end
    endtask

    task automatic test_mask_clamp();
        logic [7:0] exp_b[5];
        exp_b[0] = 8'hF0; exp_b[1] = 8'h12; exp_b[2] = 8'h34; exp_b[3] = 8'h56; exp_b[4] = 8'h78;
        do_reset();
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 6'd4, 1'b0);
        send(32'h0, 6'd4, 1'b0);
        send(32'h1234_5678, 6'd40, 1'b0);
        wait_bytes(5);
        for (int i = 0; i < 5 && i < r_bytes.size(); i++) begin
            n_cmp++;
            if (r_bytes[i] !== exp_b[i]) begin n_fail++; $display("FAIL mask_byte%0d: %02h req %02h", i, r_bytes[i], exp_b[i]); end
        end
        n_cmp++; if (bitcount !== 32'd40) begin n_fail++; $display("FAIL clamp_bitcount: %0d req 40", bitcount); end
        send(32'hDEAD_BEEF, 6'd0, 1'b0);
        step();
        n_cmp++; if (bitcount !== 32'd40 || idle !== 1'b1) begin n_fail++; $display("FAIL n0_noop: bc=%0d idle=%0b req 40/1", bitcount, idle); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b[12];
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2]  = 8'hBE; exp_b[3]  = 8'hEF;
        exp_b[4] = 8'h01; exp_b[5] = 8'h23; exp_b[6]  = 8'h45; exp_b[7]  = 8'h67;
        exp_b[8] = 8'hCA; exp_b[9] = 8'hFE; exp_b[10] = 8'hF0; exp_b[11] = 8'h0D;
        do_reset();
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 6'd32, 1'b0);
        send(32'h0123_4567, 6'd32, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready=%0b req 0", in_ready); end
        in_valid = 1'b1;
        in_val   = 32'hCAFE_F00D;
        in_n     = 6'd32;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (in_ready !== 1'b0 || out_byte !== 8'hDE || out_valid !== 1'b1 || bitcount !== 32'd64) begin
                n_fail++;
                $display("FAIL bp_stall%0d: rdy=%0b byte=%02h valid=%0b bc=%0d req 0/DE/1/64", i, in_ready, out_byte, out_valid, bitcount);
            end
        end
        out_ready = 1'b1;
        send(32'hCAFE_F00D, 6'd32, 1'b0);
        wait_bytes(12);
        for (int i = 0; i < 12 && i < r_bytes.size(); i++) begin
            n_cmp++;
            if (r_bytes[i] !== exp_b[i]) begin n_fail++; $display("FAIL bp_byte%0d: %02h req %02h", i, r_bytes[i], exp_b[i]); end
        end
        n_cmp++; if (bitcount !== 32'd96) begin n_fail++; $display("FAIL bp_bitcount: %0d req 96", bitcount); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[4];
        exp_b[0] = 8'hFF; exp_b[1] = 8'hA5; exp_b[2] = 8'h3C; exp_b[3] = 8'hF6;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(32'h1, 6'd1, 1'b0);
        // Each of these lands in the same cycle as the previous byte's pop.
        send(32'hA5, 6'd8, 1'b0);
        send(32'h3C, 6'd8, 1'b0);
        send(32'hFF, 6'd4, 1'b0);
        send(32'h6, 6'd4, 1'b0);
        wait_bytes(4);
        for (int i = 0; i < 4 && i < r_bytes.size(); i++) begin
            n_cmp++;
            if (r_bytes[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_byte%0d: %02h req %02h", i, r_bytes[i], exp_b[i]); end
        end
        n_cmp++; if (bitcount !== 32'd32) begin n_fail++; $display("FAIL b2b_bitcount: %0d req 32", bitcount); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        send(32'h000F_FFFF, 6'd20, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || bitcount !== 32'd20) begin n_fail++; $display("FAIL mid_pre: valid=%0b bc=%0d req 1/20", out_valid, bitcount); end
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_val    = 32'hFFFF_FFFF;
        in_n      = 6'd32;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || bitcount !== 32'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL mid_reset: valid=%0b bc=%0d idle=%0b req 0/0/1", out_valid, bitcount, idle); end
        repeat (5) step();
        n_cmp++; if (r_bytes.size() !== 0) begin n_fail++; $display("FAIL mid_stale: %0d bytes req 0", r_bytes.size()); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_val    = '0;
        in_n      = '0;
        in_align  = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_start_code();
        test_align();
        test_mask_clamp();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/putbits.md
# putbits

MSB-first bitstream writer for the MPEG encoder path. It is the write-side counterpart of the decoder's bit-buffer flush logic: it accepts variable-length fields of 0–32 bits, packs them into a byte stream, and supports byte alignment with zero padding. It sits between the encoder's field-emitting control logic and the byte-oriented output sink (FIFO or memory writer). It also keeps a running count of emitted bits, as `bitcount` does in mpeg2enc.

## Interface
Parameters:
- `ACC_W`, default 64: accumulator width in bits. Fixed at 64; other values are unsupported.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset: synchronous, active-high
- `in_valid`  in  1  command present
- `in_ready`  out  1  command accepted when `in_valid && in_ready`
- `in_val`  in  32  field value, right-justified; only the low `in_n` bits are used
- `in_n`  in  6  field length; 0 = no-op, 1–32 = length, 33–63 = clamped to 32
- `in_align`  in  1  alignment command; `in_val` and `in_n` are ignored
- `out_valid`  out  1  `out_byte` valid
- `out_ready`  in  1  sink accepts the byte when `out_valid && out_ready`
- `out_byte`  out  8  next stream byte, in order
- `bitcount`  out  32  total bits accepted, including padding; wraps modulo 2^32
- `idle`  out  1  no pending bits (`cnt == 0`)

## Operation
- State:
  - `acc[63:0]`: pending bits, left-justified; the oldest bit is at bit 63.
  - `cnt[6:0]`: pending bit count, 0–64.
  - `bitcount[31:0]`.
- Combinational outputs, all derived from registered state only (no path from `out_ready` or `in_valid`):
  - `in_ready = (cnt <= 32)`
  - `out_valid = (cnt >= 8)`
  - `out_byte = acc[63:56]`
  - `idle = (cnt == 0)`
- Accept field (n = effective length, 1–32):
  - masked value `v = in_val & ((1<<n)-1)`
  - `v` is placed at `acc` bit positions `[63-c' : 64-c'-n]`, where `c'` is `cnt` after any same-cycle byte pop
  - `cnt' = c' + n`
  - `bitcount += n`
- Accept with n = 0: handshake completes; no state change.
- Accept align: `pad = (8 - c'[2:0]) & 7`. Zero bits are appended, so `cnt' = c' + pad` and `bitcount += pad`. With `pad = 0`, align is a no-op.
- Byte pop on `out_valid && out_ready`: `acc <<= 8` with zero fill; `cnt -= 8`.
- Simultaneous pop and accept in one cycle: the pop applies first (`c' = cnt - 8`), then the field is inserted. Byte order is always preserved.
- Bits beyond `cnt` in `acc` are always zero.
- A trailing partial byte (`cnt` in 1–7) is never emitted until an align or further bits complete it. The encoder issues align before end of stream.
- `in_val` bits above `n` never reach the stream.

## Timing
- Reset values:
  - `acc = 0`, `cnt = 0`, `bitcount = 0`
  - `in_ready = 1`, `out_valid = 0`, `out_byte = 0x00`, `idle = 1`
- Reset is synchronous and overrides everything. Reset mid-operation discards all pending bits with no further output; an in-flight handshake in the reset cycle is dropped.
- Latency: a field accepted at edge t that completes a byte gives `out_valid = 1` in the cycle after t. Minimum accept-to-byte latency is 1 cycle.
- Throughput:
  - input: one command per cycle while `cnt <= 32`
  - output: one byte per cycle
  - sustained 32-bit fields therefore backpressure until the output drains
- Full condition: `cnt > 32` drops `in_ready`. The 64-bit accumulator never overflows, because the maximum reachable `cnt` is 32 + 32 = 64.
- Empty condition: `cnt < 8` gives `out_valid = 0`, even when `cnt > 0`.
- `out_byte` and `out_valid` hold stable while `out_ready = 0`.
- `bitcount` updates on the accept edge and is visible the next cycle.

## Test plan
- Reset behaviour: after rst → `in_ready = 1`, `out_valid = 0`, `idle = 1`, `bitcount = 0`.
- Start code: field (0x000001B3, n=32) with `out_ready = 1` → bytes 00, 00, 01, B3 on consecutive cycles starting 1 cycle after accept; `bitcount = 32`; then `idle = 1`.
- Align: (0x5, n=3), then align → single byte 0xA0; `bitcount = 8`. Align issued again while idle → no byte; `bitcount` stays 8.
- Masking and clamping:
  - (0xFFFFFFFF, n=4) then (0x0, n=4) → 0xF0
  - (0x12345678, n=40) → treated as n=32 → 12, 34, 56, 78
  - (x, n=0) → no change
- Backpressure: `out_ready = 0`; two 32-bit fields 0xDEADBEEF and 0x01234567 are accepted; `cnt = 64`, `in_ready = 0`; a third command stalls. Then `out_ready = 1` → DE AD BE EF 01 23 45 67 in order; the third command is accepted once `cnt <= 32`.
- Simultaneous pop and accept, and reset: eight (0x1, n=1) fields with `out_ready = 1` → byte 0xFF; pops overlapping new fields preserve order. Asserting rst with `cnt = 20` → `out_valid = 0`, `bitcount = 0` next cycle, and no stale bytes afterwards.
